// File: rtl/sweep_accumulator_if.sv
// sweep_accumulator_if: sample-stream, control and read-out signals of the sweep accumulator.
// master drives stimulus and read requests; slave is the accumulator itself.
interface sweep_accumulator_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ACC_W  = 29,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CNT_W  = 17
);
  logic              start;
  logic [ADDR_W-1:0] points;
  logic [CNT_W-1:0]  measures;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cnt_point;
  logic [CNT_W-1:0]  cnt_measure;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ACC_W-1:0]  rd_data;
  logic              rd_valid;
  logic              overflow;

  modport master (
    output start, points, measures, sample_valid, sample, rd_en, rd_addr,
    input  busy, done, cnt_point, cnt_measure, rd_data, rd_valid, overflow
  );

  modport slave (
    input  start, points, measures, sample_valid, sample, rd_en, rd_addr,
    output busy, done, cnt_point, cnt_measure, rd_data, rd_valid, overflow
  );
endinterface

// File: rtl/sweep_accumulator.sv
// sweep_accumulator: coherent averager that sums `measures` sweeps of `points` samples,
// point by point, into an internal RAM through a two-stage read-modify-write pipeline.
// The first sweep overwrites instead of accumulating. Read-out is allowed only in idle.
// Build macro ACCUM_SATURATE_EN: sums clamp to all-ones on carry-out and a sticky overflow
// flag is raised; without it sums wrap and overflow is tied low.
module sweep_accumulator #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ACC_W  = 29,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CNT_W  = 17
) (
  input logic                clk,
  input logic                aclr,
  sweep_accumulator_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StAccum, StFlush} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] points_q, cnt_point_q;
  logic [CNT_W-1:0]  measures_q, cnt_measure_q;

  logic start_ok, start_zero, start_run, accept, rd_ok, busy;
  logic last_point, last_sweep, last_sample;

  // Pipeline stage 1 (address issued to RAM) and stage 2 (RAM data available, write)
  logic              s1_valid_q, s1_first_q, s1_last_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_sample_q;
  logic              s2_valid_q, s2_first_q, s2_last_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [DATA_W-1:0] s2_sample_q;
  logic [ACC_W-1:0]  ram_q, addend, sum;
  logic              wr_last_q, done_q;

  logic              rd_s1_valid_q, rd_valid_q;
  logic [ADDR_W-1:0] rd_s1_addr_q;
  logic [ACC_W-1:0]  rd_raw_q;

  logic [ACC_W-1:0] ram [Depth];

  assign start_zero  = (bus.points == '0) || (bus.measures == '0);
  assign start_run   = start_ok & ~start_zero;
  assign last_point  = cnt_point_q == points_q - ADDR_W'(1);
  assign last_sweep  = cnt_measure_q == measures_q - CNT_W'(1);
  assign last_sample = accept & last_point & last_sweep;

  // FSM state register
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_run) state_d = StAccum;
      StAccum: if (last_sample) state_d = StFlush;
      StFlush: if (wr_last_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and per-state strobes
  always_comb begin
    busy     = 1'b0;
    start_ok = 1'b0;
    accept   = 1'b0;
    rd_ok    = 1'b0;
    unique case (state_q)
      StIdle: begin
        start_ok = bus.start;
        rd_ok    = bus.rd_en;
      end
      StAccum: begin
        busy   = 1'b1;
        accept = bus.sample_valid;
      end
      StFlush: busy = 1'b1;
      default: ;
    endcase
  end

  // Acquisition parameters, point/sweep counters and done generation
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      points_q      <= '0;
      measures_q    <= '0;
      cnt_point_q   <= '0;
      cnt_measure_q <= '0;
      wr_last_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      if (start_run) begin
        points_q      <= bus.points;
        measures_q    <= bus.measures;
        cnt_point_q   <= '0;
        cnt_measure_q <= '0;
      end else if (accept) begin
        if (last_point) begin
          cnt_point_q   <= '0;
          cnt_measure_q <= cnt_measure_q + CNT_W'(1);
        end else begin
          cnt_point_q <= cnt_point_q + ADDR_W'(1);
        end
      end
      wr_last_q <= s2_valid_q & s2_last_q;
      // Empty acquisitions finish immediately without touching the RAM
      done_q    <= wr_last_q | (start_ok & start_zero);
    end
  end

  // Read-modify-write and read-out pipeline control
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      s1_valid_q    <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_addr_q     <= '0;
      s1_sample_q   <= '0;
      s2_valid_q    <= 1'b0;
      s2_first_q    <= 1'b0;
      s2_last_q     <= 1'b0;
      s2_addr_q     <= '0;
      s2_sample_q   <= '0;
      rd_s1_valid_q <= 1'b0;
      rd_s1_addr_q  <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      s1_valid_q    <= accept;
      s1_first_q    <= cnt_measure_q == '0;
      s1_last_q     <= last_sample;
      s1_addr_q     <= cnt_point_q;
      s1_sample_q   <= bus.sample;
      s2_valid_q    <= s1_valid_q;
      s2_first_q    <= s1_first_q;
      s2_last_q     <= s1_last_q;
      s2_addr_q     <= s1_addr_q;
      s2_sample_q   <= s1_sample_q;
      rd_s1_valid_q <= rd_ok;
      rd_s1_addr_q  <= bus.rd_addr;
      rd_valid_q    <= rd_s1_valid_q;
    end
  end

  assign addend = s2_first_q ? '0 : ram_q;

`ifdef ACCUM_SATURATE_EN
  logic [ACC_W:0] sum_wide;
  logic           carry;
  logic           overflow_q;

  // Saturating add: clamp to all-ones when the carry-out is set
  always_comb begin
    sum_wide = {1'b0, addend} + (ACC_W + 1)'(s2_sample_q);
    carry    = sum_wide[ACC_W];
    sum      = carry ? '1 : sum_wide[ACC_W-1:0];
  end

  // Sticky overflow, cleared by the next accepted acquisition
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)                     overflow_q <= 1'b0;
    else if (start_run)           overflow_q <= 1'b0;
    else if (s2_valid_q && carry) overflow_q <= 1'b1;
  end

  assign bus.overflow = overflow_q;
`else
  // Wrapping add modulo 2**ACC_W
  always_comb begin
    sum = addend + ACC_W'(s2_sample_q);
  end

  assign bus.overflow = 1'b0;
`endif

  // Accumulation RAM; stage-2 sum is forwarded when the same point is read back to back
  always_ff @(posedge clk) begin
    if (s2_valid_q) ram[s2_addr_q] <= sum;
    ram_q    <= (s2_valid_q && (s2_addr_q == s1_addr_q)) ? sum : ram[s1_addr_q];
    rd_raw_q <= ram[rd_s1_addr_q];
  end

  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.cnt_point   = cnt_point_q;
  assign bus.cnt_measure = cnt_measure_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_valid_q ? rd_raw_q : '0;
endmodule

// File: tb/tb_sweep_accumulator.sv
// tb_sweep_accumulator: directed and randomized stimulus for sweep_accumulator, checked every
// cycle against a transaction-level model, plus literal expectations from hand arithmetic.
module tb_sweep_accumulator;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned ACC_W  = 29;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CNT_W  = 17;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam longint      MAXV   = (longint'(1) << ACC_W) - 1;

  logic clk = 1'b0;
  logic aclr = 1'b1;
  logic aclr2 = 1'b1;
  always #5 clk = ~clk;

  sweep_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();
  sweep_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .aclr(aclr), .bus(bus)
  );

  sweep_accumulator_if #(.DATA_W(12), .ACC_W(13), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus2();
  sweep_accumulator #(.DATA_W(12), .ACC_W(13), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut2 (
    .clk(clk), .aclr(aclr2), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_ram [DEPTH];
  bit     m_known [DEPTH];
  int     phase = 0;  // 0 idle, 1 collecting samples, 2 draining
  int     drain = 0;
  int     m_points = 0, m_measures = 0;
  bit     e_busy = 0, e_done = 0, e_ovf = 0, e_rdv = 0, e_rdk = 0;
  int     e_cp = 0, e_cm = 0;
  longint e_rdd = 0;
  bit     p1v = 0, p1k = 0;
  longint p1d = 0;

  task automatic model_reset();
    if (phase != 0)
      for (int a = 0; a < m_points; a++) m_known[a] = 0;  // in-flight writes lost
    phase = 0; drain = 0;
    e_busy = 0; e_done = 0; e_ovf = 0; e_rdv = 0; e_rdk = 0; e_cp = 0; e_cm = 0;
    p1v = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied
  task automatic model_step();
    bit     nd;
    longint s;
    int     a;
    nd = 0;
    e_rdv = p1v; e_rdd = p1d; e_rdk = p1k;
    p1v = 0;
    case (phase)
      0: begin
        if (bus.start) begin
          if (bus.points == 0 || bus.measures == 0) nd = 1;
          else begin
            m_points = int'(bus.points); m_measures = int'(bus.measures);
            e_cp = 0; e_cm = 0; e_ovf = 0; phase = 1;
          end
        end
        if (bus.rd_en) begin
          p1v = 1; p1d = m_ram[bus.rd_addr]; p1k = m_known[bus.rd_addr];
        end
      end
      1: begin
        if (bus.sample_valid) begin
          a = e_cp;
          s = ((e_cm == 0) ? 0 : m_ram[a]) + longint'(bus.sample);
          if (s > MAXV) begin
`ifdef ACCUM_SATURATE_EN
            s = MAXV; e_ovf = 1;
`else
            s = s - (MAXV + 1);
`endif
          end
          m_ram[a] = s;
          if (e_cm == 0) m_known[a] = 1;
          e_cp++;
          if (e_cp == m_points) begin
            e_cp = 0; e_cm++;
            if (e_cm == m_measures) begin phase = 2; drain = 2; end
          end
        end
      end
      default: begin
        if (drain == 0) begin nd = 1; phase = 0; end
        else drain--;
      end
    endcase
    e_busy = phase != 0;
    e_done = nd;
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (aclr) begin
      model_reset();
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_overflow", bus.overflow, 0);
    end else begin
      check("busy", bus.busy, e_busy);
      check("done", bus.done, e_done);
      check("overflow", bus.overflow, e_ovf);
      check("rd_valid", bus.rd_valid, e_rdv);
      check("cnt_point", bus.cnt_point, e_cp);
      check("cnt_measure", bus.cnt_measure, e_cm);
      if (e_rdv && e_rdk) check("rd_data", bus.rd_data, e_rdd);
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_acq(input int p, input int m);
    bus.points = ADDR_W'(p); bus.measures = CNT_W'(m); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drive_sample(input int v);
    bus.sample_valid = 1'b1; bus.sample = DATA_W'(v);
    tick();
    bus.sample_valid = 1'b0;
  endtask

  // Cycles from the last accepting edge until done is seen
  task automatic wait_done(input string name, input int exp_n);
    int n; bit seen;
    n = 0; seen = 0;
    while (!seen && n < 50) begin
      tick(); n++;
      if (bus.done) seen = 1;
    end
    check(name, seen ? n : 999, exp_n);
    check({name, "_busy_low"}, bus.busy, 0);
  endtask

  task automatic read_chk(input string name, input int addr, input longint exp);
    bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(addr);
    tick();
    bus.rd_en = 1'b0;
    check({name, "_valid_early"}, bus.rd_valid, 0);
    tick();
    check({name, "_valid"}, bus.rd_valid, 1);
    check(name, bus.rd_data, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    bus.start = 0; bus.points = 0; bus.measures = 0; bus.sample_valid = 0; bus.sample = 0;
    bus.rd_en = 0; bus.rd_addr = 0;
    bus2.start = 0; bus2.points = 0; bus2.measures = 0; bus2.sample_valid = 0;
    bus2.sample = 0; bus2.rd_en = 0; bus2.rd_addr = 0;
    repeat (3) tick();
    check("reset_cnt_point", bus.cnt_point, 0);
    check("reset_cnt_measure", bus.cnt_measure, 0);
    check("reset_rd_data", bus.rd_data, 0);
    aclr = 1'b0; aclr2 = 1'b0;
    tick();

    // 4 points x 3 sweeps of 1,2,3,4
    start_acq(4, 3);
    for (int s = 0; s < 3; s++)
      for (int p = 0; p < 4; p++) drive_sample(p + 1);
    wait_done("t1_done_latency", 3);
    check("t1_model_pin", m_ram[3], 12);
    for (int a = 0; a < 4; a++) read_chk("t1_read", a, 3 * (a + 1));

    // Single sweep overwrites, untouched point keeps old value
    start_acq(2, 1);
    drive_sample(100);
    drive_sample(200);
    wait_done("t2_done_latency", 3);
    read_chk("t2_read0", 0, 100);
    read_chk("t2_read1", 1, 200);
    read_chk("t2_read2", 2, 9);

    // One point, back-to-back: forwarding path
    start_acq(1, 5);
    for (int i = 0; i < 5; i++) drive_sample(7);
    wait_done("t3_done_latency", 3);
    read_chk("t3_read0", 0, 35);

    // Sparse valid with an ignored start mid-run
    start_acq(3, 2);
    for (int i = 0; i < 6; i++) begin
      drive_sample(5);
      if (i != 5) begin
        if (i == 2) begin bus.points = 7; bus.measures = 9; bus.start = 1'b1; end
        tick();
        bus.start = 1'b0;
        tick();
      end
    end
    wait_done("t4_done_latency", 3);
    for (int a = 0; a < 3; a++) read_chk("t4_read", a, 10);
    read_chk("t4_read3_old", 3, 12);

    // Empty acquisitions
    start_acq(0, 4);
    check("t5_done_p0", bus.done, 1);
    check("t5_busy_p0", bus.busy, 0);
    tick();
    check("t5_done_p0_pulse", bus.done, 0);
    start_acq(3, 0);
    check("t5_done_m0", bus.done, 1);
    check("t5_busy_m0", bus.busy, 0);
    tick();
    read_chk("t5_read0", 0, 10);

    // Abort mid-acquisition
    start_acq(8, 2);
    for (int i = 0; i < 5; i++) begin
      bus.sample_valid = 1'b1; bus.sample = DATA_W'(i + 1);
      tick();
    end
    aclr = 1'b1;
    #1;
    check("t6_busy_abort", bus.busy, 0);
    check("t6_done_abort", bus.done, 0);
    bus.sample_valid = 1'b0;
    tick(); tick();
    aclr = 1'b0;
    seen = 0;
    repeat (6) begin tick(); if (bus.done) seen = 1; end
    check("t6_no_done", seen, 0);

    // Randomized acquisitions and read-out
    for (int r = 0; r < 8; r++) begin
      int p, m;
      p = (r == 3) ? 1 : $urandom_range(1, 12);
      m = $urandom_range(1, 4);
      start_acq(p, m);
      n = 0;
      while (bus.busy && n < 500) begin
        bus.sample_valid = ($urandom_range(0, 9) < 7);
        bus.sample = DATA_W'($urandom_range(0, 4095));
        bus.rd_en = ($urandom_range(0, 3) == 0);
        bus.rd_addr = ADDR_W'($urandom_range(0, 15));
        bus.start = ($urandom_range(0, 15) == 0);
        bus.points = ADDR_W'($urandom_range(0, 15));
        tick(); n++;
      end
      bus.sample_valid = 0; bus.rd_en = 0; bus.start = 0;
      check("rnd_acq_finished", bus.busy, 0);
      for (int a = 0; a < 16; a++) begin
        bus.rd_en = ($urandom_range(0, 3) != 0);
        bus.rd_addr = ADDR_W'(a);
        bus.sample_valid = $urandom_range(0, 1);
        tick();
      end
      bus.rd_en = 0; bus.sample_valid = 0;
      repeat (3) tick();
    end

    // Narrow accumulator: 3 x 4095 into 13 bits
    bus2.points = 1; bus2.measures = 3; bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    bus2.sample = 12'd4095; bus2.sample_valid = 1'b1;
    repeat (3) tick();
    bus2.sample_valid = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 50) begin tick(); n++; if (bus2.done) seen = 1; end
    check("t7_done_latency", seen ? n : 999, 3);
`ifdef ACCUM_SATURATE_EN
    check("t7_overflow", bus2.overflow, 1);
`else
    check("t7_overflow", bus2.overflow, 0);
`endif
    bus2.rd_en = 1'b1; bus2.rd_addr = 0;
    tick();
    bus2.rd_en = 1'b0;
    tick();
    check("t7_rd_valid", bus2.rd_valid, 1);
`ifdef ACCUM_SATURATE_EN
    check("t7_read0", bus2.rd_data, 8191);
`else
    check("t7_read0", bus2.rd_data, 4093);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
